alu_core: RTL
=============

Name: alu_core

Overview:
- 8-bit two-mode logic ALU; the responder side of the ALU command interface.
- Samples one command per clock while enabled and returns a registered result on alu_out.
- Raises a sticky interrupt on specific result values; the interrupt stays high until software clears it.
- Drop-in DUT for the existing interface DUT modport; the bench's command/result monitors observe it unchanged.

Parameters:
- DATA_W, 8, width of alu_in_a, alu_in_b, alu_out.
- IRQ_EN, 1, 0 forces alu_irq low permanently; result path is unaffected.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_enable  in  1  global enable; a command is accepted only when high.
- alu_enable_a  in  1  selects mode A for the current command.
- alu_enable_b  in  1  selects mode B for the current command.
- alu_op_a  in  2  mode A opcode.
- alu_op_b  in  2  mode B opcode.
- alu_in_a  in  DATA_W  operand A.
- alu_in_b  in  DATA_W  operand B.
- alu_irq_clr  in  1  interrupt clear, sampled each edge.
- alu_out  out  DATA_W  registered result.
- alu_irq  out  1  sticky interrupt flag.

Behaviour:
- Reset (rst_n low, asynchronous): alu_out=0x00, alu_irq=0. Takes effect immediately, including mid-command. The first edge after rst_n rises is a normal sampling edge.
- Command valid at an edge when alu_enable=1 and exactly one of alu_enable_a/alu_enable_b is 1.
- Mode A ops (alu_op_a): 00 a AND b; 01 NOT(a AND b); 10 a OR b; 11 a XOR b.
- Mode B ops (alu_op_b): 00 NOT(a XOR b); 01 a AND b; 10 NOT(a OR b); 11 a OR b.
- All ops are bitwise at DATA_W; no carry and no width growth.
- Latency: the result is registered at the sampling edge and visible on alu_out immediately after it (1 cycle). Back-to-back valid commands are accepted every cycle.
- Hold cases: alu_enable=0, both mode enables 0, or both 1 (illegal). alu_out holds its previous value and no interrupt is generated. Illegal commands are otherwise ignored.
- IRQ state machine, two states:
  - IDLE (alu_irq=0) -> PENDING on a valid command whose computed result matches a trigger.
  - PENDING (alu_irq=1) -> IDLE on an edge with alu_irq_clr=1 and no new trigger.
- Triggers:
  - Mode A: op 00 result 0xFF; op 01 result 0x00; op 10 result 0xF8.
  - Mode B: op 00 result 0xF1; op 01 result 0xF4; op 10 result 0xFF.
  - Mode A op 11 and mode B op 11 never trigger.
- Trigger and alu_irq_clr on the same edge: trigger wins, alu_irq stays or becomes 1.
- alu_irq_clr in IDLE: no effect.
- alu_irq_clr is honoured regardless of alu_enable.
- A trigger while PENDING: remains PENDING; events are not counted.
- alu_irq is registered and asserts the same edge alu_out shows the triggering result.
- IRQ_EN=0: state machine held in IDLE.

Test Plan:
- Mode A XOR: enable=1, en_a=1, op_a=11, a=0x3C, b=0x0F -> alu_out=0x33 after 1 edge, alu_irq=0.
- Mode A AND trigger: op_a=00, a=0xFF, b=0xFF -> alu_out=0xFF, alu_irq=1. Then irq_clr=1 for one cycle with enable=0 -> alu_irq=0, alu_out still 0xFF.
- Mode B XNOR trigger with simultaneous clear: en_b=1, op_b=00, a=0x0E, b=0x00, irq_clr=1 -> alu_out=0xF1, alu_irq=1 (set beats clear).
- Illegal/idle hold: after alu_out=0x33, drive en_a=1, en_b=1, op_a=00, a=b=0xFF; then enable=0 -> alu_out stays 0x33 both cycles, alu_irq=0.
- Reset mid-stream: back-to-back commands, rst_n pulled low between edges -> alu_out=0x00 and alu_irq=0 immediately. First command after release, mode B op 01, a=0xF4, b=0xFF -> alu_out=0xF4, alu_irq=1.

Source files
------------

// File: rtl/alu_core.sv
// 8-bit two-mode logic ALU with a registered result and a sticky result-match interrupt.
// The interrupt is a two-state FSM, set by trigger values and cleared by alu_irq_clr.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | no interrupt pending, alu_irq = 0
//   ST_PENDING | a trigger result was produced and not yet cleared, alu_irq = 1
module alu_core #(
  parameter int DATA_W = 8,
  parameter bit IRQ_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_enable,
  input  logic              alu_enable_a,
  input  logic              alu_enable_b,
  input  logic [1:0]        alu_op_a,
  input  logic [1:0]        alu_op_b,
  input  logic [DATA_W-1:0] alu_in_a,
  input  logic [DATA_W-1:0] alu_in_b,
  input  logic              alu_irq_clr,
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_irq
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } irq_state_e;

  irq_state_e        state_q, state_d;
  logic [DATA_W-1:0] alu_out_q, alu_out_d;
  logic [DATA_W-1:0] result;
  logic              cmd_valid;
  logic              hit;
  logic              trigger;

  // Exactly one mode enable qualifies a command; both set is illegal and ignored.
  assign cmd_valid = alu_enable & (alu_enable_a ^ alu_enable_b);

  always_comb begin
    result = '0;
    hit    = 1'b0;
    if (alu_enable_a) begin
      case (alu_op_a)
        2'b00: begin
          result = alu_in_a & alu_in_b;
          hit    = (result == DATA_W'(8'hFF));
        end
        2'b01: begin
          result = ~(alu_in_a & alu_in_b);
          hit    = (result == DATA_W'(8'h00));
        end
        2'b10: begin
          result = alu_in_a | alu_in_b;
          hit    = (result == DATA_W'(8'hF8));
        end
        default: result = alu_in_a ^ alu_in_b;
      endcase
    end else begin
      case (alu_op_b)
        2'b00: begin
          result = ~(alu_in_a ^ alu_in_b);
          hit    = (result == DATA_W'(8'hF1));
        end
        2'b01: begin
          result = alu_in_a & alu_in_b;
          hit    = (result == DATA_W'(8'hF4));
        end
        2'b10: begin
          result = ~(alu_in_a | alu_in_b);
          hit    = (result == DATA_W'(8'hFF));
        end
        default: result = alu_in_a | alu_in_b;
      endcase
    end
  end

  assign trigger   = cmd_valid & hit;
  assign alu_out_d = cmd_valid ? result : alu_out_q;

  // A trigger on the same edge as a clear keeps the interrupt set.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (trigger) state_d = ST_PENDING;
      ST_PENDING: if (alu_irq_clr && !trigger) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (!IRQ_EN) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      alu_out_q <= '0;
    end else begin
      state_q   <= state_d;
      alu_out_q <= alu_out_d;
    end
  end

  assign alu_out = alu_out_q;
  assign alu_irq = (state_q == ST_PENDING);

endmodule
